// File: rtl/hmc_tx_token_ctrl_if.sv
// Signal bundle between the TX token tracker, TX arbitration, RX return-token extraction and the register file.
// The master drives requests, returns and control. The slave (the tracker) drives grant and status.
interface hmc_tx_token_ctrl_if #(
  parameter int FPW                = 4,
  parameter int LOG_FPW            = 2,
  parameter int LOG_MAX_HMC_TOKENS = 10,
  parameter int RTC_WIDTH          = 5
);
  logic                          load_tokens;
  logic [LOG_MAX_HMC_TOKENS-1:0] rf_hmc_init_tokens;
  logic                          tx_req_valid;
  logic [LOG_FPW:0]              tx_req_flits;
  logic                          tx_req_grant;
  logic [FPW-1:0]                rx_rtc_valid;
  logic [FPW*RTC_WIDTH-1:0]      rx_rtc;
  logic [LOG_MAX_HMC_TOKENS-1:0] tokens_av;
  logic                          tokens_low;
  logic                          token_overflow;
  logic                          clear_error;

  modport master (
    output load_tokens, rf_hmc_init_tokens, tx_req_valid, tx_req_flits,
           rx_rtc_valid, rx_rtc, clear_error,
    input  tx_req_grant, tokens_av, tokens_low, token_overflow
  );

  modport slave (
    input  load_tokens, rf_hmc_init_tokens, tx_req_valid, tx_req_flits,
           rx_rtc_valid, rx_rtc, clear_error,
    output tx_req_grant, tokens_av, tokens_low, token_overflow
  );
endinterface

// File: rtl/hmc_tx_token_ctrl.sv
// TX flow-control token tracker. It grants flit requests against the free HMC input-buffer tokens
// and credits RTC returns through a one-stage pipelined adder.
module hmc_tx_token_ctrl #(
  parameter int FPW                = 4,
  parameter int LOG_FPW            = 2,
  parameter int LOG_MAX_HMC_TOKENS = 10,
  parameter int RTC_WIDTH          = 5,
  parameter int LOW_WATERMARK      = 16
) (
  input logic               clk_hmc,
  input logic               res_n,
  hmc_tx_token_ctrl_if.slave tok
);
  localparam int TW = LOG_MAX_HMC_TOKENS;
  localparam int SW = LOG_MAX_HMC_TOKENS + 1;
  localparam int CW = LOG_MAX_HMC_TOKENS + 2;
  localparam logic [CW-1:0] MAX_TOKENS = {2'b00, {TW{1'b1}}};

  typedef enum logic {UNINIT, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tokens_q, tokens_d;
  logic            low_q, low_d;
  logic            ovf_q, ovf_d;
  logic [SW-1:0]   rtc_sum_q, rtc_sum_d;
  logic            grant;
  logic [CW-1:0]   next_count;
  logic            ovf_set;

  always_comb begin
    rtc_sum_d = '0;
    for (int i = 0; i < FPW; i++) begin
      if (tok.rx_rtc_valid[i])
        rtc_sum_d = rtc_sum_d + SW'(tok.rx_rtc[RTC_WIDTH*i +: RTC_WIDTH]);
    end
  end

  // The grant looks only at the registered count, so returns in flight never enable it early.
  always_comb begin
    grant = (state_q == ACTIVE) && tok.tx_req_valid && !tok.load_tokens &&
            (tok.tx_req_flits <= (LOG_FPW+1)'(FPW)) &&
            (TW'(tok.tx_req_flits) <= tokens_q);
  end

  always_comb begin
    state_d    = state_q;
    tokens_d   = tokens_q;
    ovf_set    = 1'b0;
    next_count = CW'(tokens_q) + CW'(rtc_sum_q) - (grant ? CW'(tok.tx_req_flits) : '0);
    if (tok.load_tokens) begin
      state_d  = ACTIVE;
      tokens_d = tok.rf_hmc_init_tokens;
    end else if (state_q == ACTIVE) begin
      if (next_count > MAX_TOKENS) begin
        tokens_d = {TW{1'b1}};
        ovf_set  = 1'b1;
      end else begin
        tokens_d = next_count[TW-1:0];
      end
    end else begin
      tokens_d = '0;
    end
    low_d = (tokens_d < TW'(LOW_WATERMARK));
    ovf_d = ovf_set || (ovf_q && !tok.clear_error);
  end

  always_ff @(posedge clk_hmc or negedge res_n) begin
    if (!res_n) begin
      state_q   <= UNINIT;
      tokens_q  <= '0;
      low_q     <= 1'b1;
      ovf_q     <= 1'b0;
      rtc_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      tokens_q  <= tokens_d;
      low_q     <= low_d;
      ovf_q     <= ovf_d;
      rtc_sum_q <= rtc_sum_d;
    end
  end

  assign tok.tx_req_grant   = grant;
  assign tok.tokens_av      = tokens_q;
  assign tok.tokens_low     = low_q;
  assign tok.token_overflow = ovf_q;
endmodule
